// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its bench.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2
  } err_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int         CNT_W      = 4;

endpackage

// File: rtl/sram_array.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module sram_array #(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
    rd <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding access, LATENCY wait states, then a
// one-cycle registered ready/err/rdata strobe.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output state_t      dbg_state
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be 0..15");
  end
  if (DEPTH_WORDS < 2 || DEPTH_WORDS > 4096 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two in 2..4096");
  end
  if ((BASE_ADDR % SPAN) != 0) begin : g_bad_base
    $error("dmem_responder: BASE_ADDR must be aligned to the memory span");
  end

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [31:0]      cap_addr, cap_wdata, cap_off;
  logic             cap_bad;
  logic             accept, resp, mem_we;
  logic [AW-1:0]    raddr;
  logic [31:0]      rd;

  assign dbg_state = state;
  assign cap_off   = cap_addr - BASE_ADDR;
  assign cap_bad   = ((cap_addr[1:0] & ALIGN_MASK) != 2'b00) || (cap_off >= SPAN);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req) next_state = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // BASE_ADDR is span-aligned, so the word index is just the address bits
  // above the byte offset. In IDLE the live address feeds the RAM so a
  // zero-latency load still gets a registered read.
  always_comb begin
    accept = (state == ST_IDLE) && req;
    resp   = (state == ST_RESP);
    mem_we = resp && cap_we && !cap_bad && reset;
    raddr  = (state == ST_IDLE) ? addr[AW+1:2] : cap_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cnt       <= CNT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      ready <= resp;
      err   <= resp && cap_bad;
      rdata <= (resp && !cap_we && !cap_bad) ? rd : '0;
    end
  end

  sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cap_addr[AW+1:2]),
    .raddr (raddr),
    .wd    (cap_wdata),
    .rd    (rd)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 4) driven against
// a word-array reference model with a timed expectation queue.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT0 = 2, LAT1 = 0, LAT2 = 4;

  // Handshake: an access is accepted on a rising edge where req=1 and the
  // responder is idle; its response is the single cycle with ready=1, which
  // begins LATENCY+1 edges after the accepting edge.

  typedef struct {
    int          k;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_n = 3'b000;
  logic [2:0]  req = 3'b000;
  logic [2:0]  we = 3'b000;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [2:0]  ready, err;
  logic [31:0] rdata [3];
  state_t      dbg [3];

  int          lat [3] = '{LAT0, LAT1, LAT2};
  logic [31:0] mem_m [3][DEPTH];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k]  = '0;
      wdata[k] = '0;
    end
  end

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]),
    .dbg_state(dbg[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]),
    .dbg_state(dbg[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT2)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2]),
    .dbg_state(dbg[2]));

  // ---------------- reference model ----------------
  function automatic err_t classify(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0;
    if (a % 4 != 0)            return ERR_ALIGN;
    if (off >= 32'(DEPTH * 4)) return ERR_RANGE;
    return ERR_NONE;
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // Builds the expectation for an access whose request is driven now and
  // accepted on the next rising edge (n_edges_ahead extra edges later).
  task automatic expect_access(int k, logic w, logic [31:0] a, logic [31:0] d, int n_edges_ahead);
    exp_t  e;
    err_t  c;
    c       = classify(a);
    e.k     = k;
    e.due   = cyc + 1 + n_edges_ahead + lat[k] + 1;
    e.err   = (c != ERR_NONE);
    e.rdata = (c == ERR_NONE && !w) ? mem_m[k][int'(a >> 2)] : 32'h0;
    if (c == ERR_NONE && w) mem_m[k][int'(a >> 2)] = d;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(int k, logic w, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    expect_access(k, w, a, d, 0);
    @(posedge clk);
    #1 req[k] = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL response_timeout: got no ready after %0d cycles, required one", t);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic random_addr(output logic [31:0] a);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
    else if (r < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else if (r < 9) a = 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
    else            a = 32'hFFFF_FFFC;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        check("err_only_with_ready", k, 32'(err[k] & ~ready[k]), 32'h0);
        if (ready[k]) begin
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ready inst%0d: got ready=1 at cycle %0d, required 0", k, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ready_cycle", k, 32'(cyc), 32'(e.due));
            check("err", k, 32'(err[k]), 32'(e.err));
            check("rdata", k, rdata[k], e.rdata);
          end
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_ready inst%0d: got no ready by cycle %0d, required at %0d",
                 exp_q[0].k, cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic        w;
    int          k;

    // Reset for 3 cycles, then idle for 10: outputs must stay quiet.
    rst_n = 3'b000;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        check("idle_ready", j, 32'(ready[j]), 32'h0);
        check("idle_err", j, 32'(err[j]), 32'h0);
        check("idle_rdata", j, rdata[j], 32'h0);
      end
      if (i == 2) rst_n = 3'b111;
    end
    check("idle_state", 0, 32'(dbg[0]), 32'(ST_IDLE));
    mon_en = 1'b1;

    // Give every word a known random value.
    for (int j = 0; j < 3; j++)
      for (int wd = 0; wd < DEPTH; wd++) begin
        issue(j, 1'b1, 32'(wd * 4), $urandom);
        wait_done();
      end

    // Store then load, LATENCY=2.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF); wait_done();
    issue(0, 1'b0, 32'h10, 32'h0);         wait_done();

    // LATENCY=0 back-to-back with req held high: store then load of 0x4.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'h1234_5678;
    expect_access(1, 1'b1, 32'h4, 32'h1234_5678, 0);
    @(negedge clk);
    we[1] = 1'b0; wdata[1] = 32'h0;
    expect_access(1, 1'b0, 32'h4, 32'h0, 1);
    @(negedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    wait_done();

    // Misaligned store must not disturb the neighbouring word.
    issue(1, 1'b1, 32'h6, 32'hFFFF_FFFF); wait_done();
    issue(1, 1'b0, 32'h4, 32'h0);         wait_done();

    // Range boundary.
    issue(0, 1'b0, 32'h100, 32'h0); wait_done();
    issue(0, 1'b0, 32'hFC, 32'h0);  wait_done();

    // Reset during WAIT on the LATENCY=4 instance aborts the store.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'hAAAA_5555;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    check("abort_to_idle", 2, 32'(dbg[2]), 32'(ST_IDLE));
    repeat (8) @(negedge clk);
    issue(2, 1'b0, 32'h8, 32'h0); wait_done();

    // Randomized traffic across all instances.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      random_addr(a);
      issue(k, w, a, $urandom);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
